// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer arbiter slice:
//   - capture sequencer state encoding
//   - default values of RAM_DEPTH, CPU_MAX_WAIT and CAP_TIMEOUT
//   - counter width helper
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int unsigned FB_RAM_DEPTH    = 38400;
    localparam int unsigned FB_CPU_MAX_WAIT = 8;
    localparam int unsigned FB_CAP_TIMEOUT  = 1048576;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_REQ  = 2'd1,
        CAP_REL  = 2'd2
    } cap_state_t;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_cap_seq.sv
// -----------------------------------------------------------------------------
// fb_cap_seq
// Frame capture handshake with the camera block.
//   HCLK        in   clock, rising edge
//   HRESET      in   asynchronous active-high reset
//   cap_req     in   one-cycle pulse starting a capture (ignored unless idle)
//   DATA_READY  in   frame-complete flag from the camera block
//   DATA_VALID  out  capture request to the camera (high only while waiting)
//   cap_busy    out  capture sequence in progress (REQ or REL)
//   cap_done    out  one-cycle pulse on REQ->REL
//   cap_err     out  one-cycle pulse when DATA_READY fails to rise in time
// -----------------------------------------------------------------------------
module fb_cap_seq
    import fb_pkg::*;
#(
    parameter int unsigned CAP_TIMEOUT = FB_CAP_TIMEOUT
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic cap_req,
    input  logic DATA_READY,
    output logic DATA_VALID,
    output logic cap_busy,
    output logic cap_done,
    output logic cap_err
);

    localparam int unsigned         TMO_W    = cnt_width(CAP_TIMEOUT);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(CAP_TIMEOUT - 1);

    cap_state_t       state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;

    // Counter is held at zero outside REQ, so it starts from zero on entry.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= CAP_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CAP_REQ && state_nxt == CAP_REQ)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
        end
    end

    // Outputs are decoded from the state register, so an asynchronous reset
    // drops DATA_VALID immediately and can never produce a done/err pulse.
    always_comb begin
        state_nxt  = state;
        DATA_VALID = 1'b0;
        cap_busy   = 1'b0;
        cap_done   = 1'b0;
        cap_err    = 1'b0;
        case (state)
            CAP_IDLE: begin
                if (cap_req)
                    state_nxt = CAP_REQ;
            end
            CAP_REQ: begin
                DATA_VALID = 1'b1;
                cap_busy   = 1'b1;
                if (DATA_READY) begin
                    state_nxt = CAP_REL;
                    cap_done  = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = CAP_IDLE;
                    cap_err   = 1'b1;
                end
            end
            CAP_REL: begin
                cap_busy = 1'b1;
                if (!DATA_READY)
                    state_nxt = CAP_IDLE;
            end
            default: state_nxt = CAP_IDLE;
        endcase
    end

endmodule

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Frame-buffer read arbiter between the display and the CPU, plus the capture
// sequencer that locks out reads while the camera writes the buffer.
//   HCLK / HRESET           clock, asynchronous active-high reset
//   cap_req                 capture start pulse
//   cap_busy/done/err       capture status
//   DATA_VALID/DATA_READY   camera handshake
//   d_req/d_addr/d_gnt      display read request, address, grant
//   c_req/c_addr/c_gnt      CPU read request, address, grant
//   d_rvalid/c_rvalid       read data valid, per owner
//   rdata                   shared read data (0 when neither rvalid is set)
//   DualRAM_RADDR/RDATA     frame-buffer read port (1-cycle read latency)
// Grant in cycle N -> address on DualRAM_RADDR in N+1 -> rvalid/rdata in N+2.
// -----------------------------------------------------------------------------
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned RAM_DEPTH    = FB_RAM_DEPTH,
    parameter int unsigned CPU_MAX_WAIT = FB_CPU_MAX_WAIT,
    parameter int unsigned CAP_TIMEOUT  = FB_CAP_TIMEOUT
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cap_req,
    output logic        cap_busy,
    output logic        cap_done,
    output logic        cap_err,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    input  logic        c_req,
    input  logic [15:0] c_addr,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] rdata,
    output logic [15:0] DualRAM_RADDR,
    input  logic [31:0] DualRAM_RDATA
);

    localparam int unsigned      WAIT_W    = cnt_width(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
    localparam logic [16:0]      DEPTH_LIM = 17'(RAM_DEPTH);

    logic [WAIT_W-1:0] wait_cnt;
    logic              c_win;
    logic              any_gnt;
    logic [15:0]       gnt_addr;

    // Read pipeline: stage 1 tracks the address cycle, stage 2 the data cycle.
    logic s1_vld, s1_cpu, s1_oor;
    logic s2_vld, s2_cpu, s2_oor;

    fb_cap_seq #(
        .CAP_TIMEOUT (CAP_TIMEOUT)
    ) u_cap_seq (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cap_req    (cap_req),
        .DATA_READY (DATA_READY),
        .DATA_VALID (DATA_VALID),
        .cap_busy   (cap_busy),
        .cap_done   (cap_done),
        .cap_err    (cap_err)
    );

    // Display wins by default; a CPU that has waited CPU_MAX_WAIT cycles wins.
    // No grants while the buffer is being written or while reset is held.
    always_comb begin
        c_win    = c_req && (!d_req || wait_cnt == WAIT_MAX);
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        if (!DATA_VALID && !HRESET) begin
            c_gnt = c_win;
            d_gnt = d_req && !c_win;
        end
        any_gnt  = c_gnt || d_gnt;
        gnt_addr = c_gnt ? c_addr : d_addr;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (!c_req || c_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            DualRAM_RADDR <= '0;
            s1_vld        <= 1'b0;
            s1_cpu        <= 1'b0;
            s1_oor        <= 1'b0;
            s2_vld        <= 1'b0;
            s2_cpu        <= 1'b0;
            s2_oor        <= 1'b0;
        end else begin
            s1_vld <= any_gnt;
            s1_cpu <= c_gnt;
            if (any_gnt) begin
                DualRAM_RADDR <= gnt_addr;
                s1_oor        <= ({1'b0, gnt_addr} >= DEPTH_LIM);
            end
            s2_vld <= s1_vld;
            s2_cpu <= s1_cpu;
            s2_oor <= s1_oor;
        end
    end

    always_comb begin
        d_rvalid = s2_vld && !s2_cpu;
        c_rvalid = s2_vld && s2_cpu;
        rdata    = (s2_vld && !s2_oor) ? DualRAM_RDATA : '0;
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

    logic        HCLK;
    logic        HRESET;
    logic        cap_req;
    logic        cap_busy, cap_done, cap_err;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_gnt, d_rvalid;
    logic        c_req;
    logic [15:0] c_addr;
    logic        c_gnt, c_rvalid;
    logic [31:0] rdata;
    logic [15:0] DualRAM_RADDR;
    logic [31:0] DualRAM_RDATA;

    int vectors     = 0;
    int miscompares = 0;

    int dv_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int dv0, dn0, er0;

    fb_arbiter #(
        .RAM_DEPTH    (38400),
        .CPU_MAX_WAIT (8),
        .CAP_TIMEOUT  (100)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .cap_req       (cap_req),
        .cap_busy      (cap_busy),
        .cap_done      (cap_done),
        .cap_err       (cap_err),
        .DATA_VALID    (DATA_VALID),
        .DATA_READY    (DATA_READY),
        .d_req         (d_req),
        .d_addr        (d_addr),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .c_req         (c_req),
        .c_addr        (c_addr),
        .c_gnt         (c_gnt),
        .c_rvalid      (c_rvalid),
        .rdata         (rdata),
        .DualRAM_RADDR (DualRAM_RADDR),
        .DualRAM_RDATA (DualRAM_RDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // RAM contents are a fixed function of the address.
    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    always @(posedge HCLK)
        DualRAM_RDATA <= ram_word(DualRAM_RADDR);

    always @(negedge HCLK) begin
        if (DATA_VALID)           dv_cnt++;
        if (cap_done)             done_cnt++;
        if (cap_err)              err_cnt++;
        if (d_rvalid && c_rvalid) both_cnt++;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET     = 1'b1;
        cap_req    = 1'b0;
        DATA_READY = 1'b0;
        d_req      = 1'b0;
        d_addr     = '0;
        c_req      = 1'b0;
        c_addr     = '0;

        // ---- reset state (requests asserted must not be granted) ----
        repeat (2) @(posedge HCLK);
        #1;
        d_req = 1'b1; c_req = 1'b1;
        #1;
        check("rst_raddr",    32'(DualRAM_RADDR), 32'h0);
        check("rst_d_gnt",    32'(d_gnt),         32'h0);
        check("rst_c_gnt",    32'(c_gnt),         32'h0);
        check("rst_d_rvalid", 32'(d_rvalid),      32'h0);
        check("rst_c_rvalid", 32'(c_rvalid),      32'h0);
        check("rst_rdata",    rdata,              32'h0);
        check("rst_dvalid",   32'(DATA_VALID),    32'h0);
        check("rst_busy",     32'(cap_busy),      32'h0);
        d_req = 1'b0; c_req = 1'b0;
        HRESET = 1'b0;
        tick();

        // ---- display burst at 0,1,2 ----
        d_req = 1'b1; d_addr = 16'd0; #1;
        check("burst_gnt0", 32'(d_gnt), 32'h1);
        tick();
        d_addr = 16'd1; #1;
        check("burst_gnt1",  32'(d_gnt),         32'h1);
        check("burst_raddr0",32'(DualRAM_RADDR), 32'h0);
        check("burst_nrv1",  32'(d_rvalid),      32'h0);
        tick();
        d_addr = 16'd2; #1;
        check("burst_gnt2",   32'(d_gnt),         32'h1);
        check("burst_raddr1", 32'(DualRAM_RADDR), 32'h1);
        check("burst_rv0",    32'(d_rvalid),      32'h1);
        check("burst_data0",  rdata,              ram_word(16'd0));
        tick();
        d_req = 1'b0; #1;
        check("burst_rv1",   32'(d_rvalid), 32'h1);
        check("burst_crv1",  32'(c_rvalid), 32'h0);
        check("burst_data1", rdata,         ram_word(16'd1));
        tick();
        check("burst_rv2",   32'(d_rvalid), 32'h1);
        check("burst_data2", rdata,         ram_word(16'd2));
        tick();
        check("burst_end_rv",   32'(d_rvalid), 32'h0);
        check("burst_end_data", rdata,         32'h0);

        // ---- CPU starvation limit: display held, CPU at 0x0010 ----
        d_req = 1'b1; d_addr = 16'h0100;
        c_req = 1'b1; c_addr = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("starve_c_denied", 32'(c_gnt), 32'h0);
            check("starve_d_gnt",    32'(d_gnt), 32'h1);
            tick();
        end
        #1;
        check("starve_c_gnt",  32'(c_gnt), 32'h1);
        check("starve_d_hold", 32'(d_gnt), 32'h0);
        tick();
        c_req = 1'b0; #1;
        check("starve_d_regnt", 32'(d_gnt),    32'h1);
        check("starve_d_rv",    32'(d_rvalid), 32'h1);
        check("starve_d_data",  rdata,         ram_word(16'h0100));
        tick();
        d_req = 1'b0; #1;
        check("starve_c_rv",    32'(c_rvalid), 32'h1);
        check("starve_c_not_d", 32'(d_rvalid), 32'h0);
        check("starve_c_data",  rdata,         ram_word(16'h0010));
        tick();
        check("starve_d_rv2",   32'(d_rvalid), 32'h1);
        check("starve_c_rv2",   32'(c_rvalid), 32'h0);
        check("starve_d_data2", rdata,         ram_word(16'h0100));
        tick();

        // ---- address range boundary ----
        c_req = 1'b1; c_addr = 16'd38400; #1;
        check("oor_c_gnt", 32'(c_gnt), 32'h1);
        tick();
        c_addr = 16'd38399; #1;
        check("last_c_gnt", 32'(c_gnt), 32'h1);
        tick();
        c_req = 1'b0; #1;
        check("oor_c_rv",   32'(c_rvalid), 32'h1);
        check("oor_data",   rdata,         32'h0);
        tick();
        check("last_c_rv",  32'(c_rvalid), 32'h1);
        check("last_data",  rdata,         ram_word(16'd38399));
        tick();

        // ---- normal capture: ready after 50 cycles, released after 10 ----
        dv0 = dv_cnt; dn0 = done_cnt;
        cap_req = 1'b1; #1;
        check("cap_idle_busy", 32'(cap_busy), 32'h0);
        tick();
        cap_req = 1'b0;
        d_req = 1'b1; c_req = 1'b1; d_addr = 16'd3; c_addr = 16'd4; #1;
        check("cap_lock_d", 32'(d_gnt),      32'h0);
        check("cap_lock_c", 32'(c_gnt),      32'h0);
        check("cap_dvalid", 32'(DATA_VALID), 32'h1);
        check("cap_busy",   32'(cap_busy),   32'h1);
        d_req = 1'b0; c_req = 1'b0;
        repeat (49) tick();
        DATA_READY = 1'b1; #1;
        check("cap_done_pulse", 32'(cap_done), 32'h1);
        tick();
        cap_req = 1'b1; #1;
        check("rel_dvalid", 32'(DATA_VALID), 32'h0);
        check("rel_busy",   32'(cap_busy),   32'h1);
        check("rel_done",   32'(cap_done),   32'h0);
        tick();
        cap_req = 1'b0;
        repeat (8) tick();
        DATA_READY = 1'b0; #1;
        check("rel_busy_last", 32'(cap_busy), 32'h1);
        tick();
        check("cap_end_busy",   32'(cap_busy),     32'h0);
        check("cap_end_dvalid", 32'(DATA_VALID),   32'h0);
        check("cap_dv_cycles",  32'(dv_cnt - dv0), 32'd50);
        check("cap_done_count", 32'(done_cnt - dn0), 32'd1);

        // ---- capture timeout (CAP_TIMEOUT = 100) ----
        dv0 = dv_cnt; er0 = err_cnt; dn0 = done_cnt;
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        repeat (98) tick();
        check("tmo_no_err_99", 32'(cap_err),    32'h0);
        check("tmo_dvalid_99", 32'(DATA_VALID), 32'h1);
        tick();
        check("tmo_err_100",   32'(cap_err),    32'h1);
        tick();
        check("tmo_dvalid_off", 32'(DATA_VALID),     32'h0);
        check("tmo_idle",       32'(cap_busy),       32'h0);
        check("tmo_err_once",   32'(err_cnt - er0),  32'd1);
        check("tmo_dv_cycles",  32'(dv_cnt - dv0),   32'd100);
        check("tmo_no_done",    32'(done_cnt - dn0), 32'd0);

        // ---- reset one cycle after a grant ----
        d_req = 1'b1; d_addr = 16'd5; #1;
        check("rstg_gnt", 32'(d_gnt), 32'h1);
        tick();
        d_req = 1'b0; #1;
        check("rstg_raddr_pre", 32'(DualRAM_RADDR), 32'h5);
        HRESET = 1'b1; #1;
        check("rstg_raddr", 32'(DualRAM_RADDR), 32'h0);
        tick();
        check("rstg_no_drv", 32'(d_rvalid), 32'h0);
        check("rstg_no_crv", 32'(c_rvalid), 32'h0);
        check("rstg_rdata",  rdata,         32'h0);
        HRESET = 1'b0;
        tick();
        check("rstg_after_rv", 32'(d_rvalid), 32'h0);

        // ---- reset during REQ ----
        dn0 = done_cnt; er0 = err_cnt;
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        repeat (4) tick();
        check("rstc_dvalid_pre", 32'(DATA_VALID), 32'h1);
        DATA_READY = 1'b1;
        HRESET = 1'b1; #1;
        check("rstc_dvalid", 32'(DATA_VALID), 32'h0);
        check("rstc_busy",   32'(cap_busy),   32'h0);
        check("rstc_done",   32'(cap_done),   32'h0);
        tick();
        HRESET = 1'b0;
        DATA_READY = 1'b0;
        repeat (2) tick();
        check("rstc_idle",    32'(cap_busy),       32'h0);
        check("rstc_no_done", 32'(done_cnt - dn0), 32'd0);
        check("rstc_no_err",  32'(err_cnt - er0),  32'd0);

        check("rvalid_exclusive", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter RAM_DEPTH, default 38400, SHALL set the number of valid 32-bit frame-buffer words (addresses 0..RAM_DEPTH-1).
REQ-002 Parameter CPU_MAX_WAIT, default 8, SHALL set the number of consecutive denied CPU cycles before the CPU is forced to win.
REQ-003 Parameter CAP_TIMEOUT, default 1048576, SHALL set the number of cycles allowed for DATA_READY to rise after DATA_VALID.
REQ-004 HCLK  in  1  sole clock; all logic rising-edge.
REQ-005 HRESET  in  1  asynchronous, active-high reset.
REQ-006 cap_req  in  1  one-cycle pulse that starts a frame capture.
REQ-007 cap_busy  out  1  capture sequence in progress.
REQ-008 cap_done  out  1  one-cycle pulse when a frame is captured.
REQ-009 cap_err  out  1  one-cycle pulse on capture timeout.
REQ-010 DATA_VALID  out  1  capture request to the camera block.
REQ-011 DATA_READY  in  1  frame-complete flag from the camera block, HCLK domain.
REQ-012 d_req  in  1  display read request.
REQ-013 d_addr  in  16  display word address.
REQ-014 d_gnt  out  1  display request accepted this cycle.
REQ-015 d_rvalid  out  1  display read data valid on rdata.
REQ-016 c_req  in  1  CPU read request.
REQ-017 c_addr  in  16  CPU word address.
REQ-018 c_gnt  out  1  CPU request accepted this cycle.
REQ-019 c_rvalid  out  1  CPU read data valid on rdata.
REQ-020 rdata  out  32  shared read data; qualified by d_rvalid or c_rvalid.
REQ-021 DualRAM_RADDR  out  16  frame-buffer read address, registered.
REQ-022 DualRAM_RDATA  in  32  frame-buffer read data, one cycle after address.

Function
REQ-023 Capture FSM SHALL have states IDLE, REQ, REL; IDLE->REQ on cap_req; REQ->REL on DATA_READY=1; REL->IDLE on DATA_READY=0; REQ->IDLE when the timeout counter reaches CAP_TIMEOUT-1.
REQ-024 DATA_VALID SHALL be 1 exactly in REQ; cap_busy SHALL be 1 in REQ and REL.
REQ-025 cap_done SHALL pulse one cycle on the REQ->REL transition; cap_err SHALL pulse one cycle on the timeout transition.
REQ-026 cap_req outside IDLE SHALL be ignored; the timeout counter SHALL clear on entering REQ.
REQ-027 While the FSM is in REQ (buffer being written), d_gnt and c_gnt SHALL be 0; reads already granted SHALL complete normally.
REQ-028 Grants SHALL be combinational in the request cycle N, at most one per cycle; requesters hold req/addr until granted.
REQ-029 Default priority: display over CPU; when the CPU wait counter equals CPU_MAX_WAIT and c_req=1, the CPU SHALL win.
REQ-030 The CPU wait counter SHALL increment each cycle with c_req=1 and c_gnt=0 (saturating at CPU_MAX_WAIT) and clear on c_gnt or c_req=0.
REQ-031 The granted address SHALL appear on DualRAM_RADDR in cycle N+1; the matching rvalid SHALL assert in cycle N+2 with rdata=DualRAM_RDATA.
REQ-032 Back-to-back grants SHALL give one result per cycle, in grant order, with the correct owner flag.
REQ-033 A granted address >= RAM_DEPTH SHALL produce rvalid in N+2 with rdata=32'h0.
REQ-034 d_rvalid and c_rvalid SHALL never be 1 in the same cycle; rdata SHALL be 0 when neither is 1.

Reset
REQ-035 On HRESET: FSM IDLE; all counters 0; DualRAM_RADDR=0; all other outputs 0; in-flight reads are discarded with no rvalid.
REQ-036 Reset mid-capture SHALL drop DATA_VALID in the same cycle, with no cap_done or cap_err pulse.

Structure
REQ-037 Package fb_pkg SHALL hold the capture state encoding and the default values of RAM_DEPTH, CPU_MAX_WAIT, and CAP_TIMEOUT.
REQ-038 The capture FSM and timeout counter SHALL be the sub-module fb_cap_seq; arbitration and the read pipeline stay in fb_arbiter.

Verification
REQ-039 Stimulus: cap_req, then DATA_READY=1 after 50 cycles, then DATA_READY=0 after 10 cycles. Response: DATA_VALID high for 50 cycles, one cap_done, cap_busy low after DATA_READY falls.
REQ-040 Stimulus: CAP_TIMEOUT=100, cap_req, DATA_READY held 0. Response: cap_err in cycle 100, DATA_VALID=0, FSM returns to IDLE.
REQ-041 Stimulus: d_req held high continuously, c_req=1 at addr 0x0010. Response: c_gnt after exactly 8 denied cycles; c_rvalid 2 cycles later with RAM word 0x0010.
REQ-042 Stimulus: d_req at addr 0,1,2 back-to-back. Response: d_rvalid for 3 consecutive cycles starting at N+2, data in order.
REQ-043 Stimulus: c_addr=38400. Response: c_gnt=1, c_rvalid at N+2, rdata=0.
REQ-044 Stimulus: HRESET asserted one cycle after a grant, and separately during REQ. Response: no rvalid, DATA_VALID=0 immediately, no cap_done.
